// File: rtl/filter_gpu_pkg.sv
// Shared types for the Filter-GPU pipeline control blocks.
//   fwd_sel_t  : operand-forward mux select (regfile / ResultW / ALUResultM)
//   hz_state_t : hazard controller sequencing state
//   REG_ADDR_W : register address width (instruction field [15:12])
package filter_gpu_pkg;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;
endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one Execute-stage source operand.
//   ra_e                    : source register in Execute
//   wa3_m, wa3_w            : destination registers in Memory / Writeback
//   reg_write_m/reg_write_w : write enables for those stages
//   fwd                     : 00 regfile, 01 ResultW, 10 ALUResultM
// Memory wins over Writeback because it holds the younger result.
module hazard_fwd_sel
  import filter_gpu_pkg::*;
#(
  parameter int RA_W = REG_ADDR_W
) (
  input  logic [RA_W-1:0] ra_e,
  input  logic [RA_W-1:0] wa3_m,
  input  logic [RA_W-1:0] wa3_w,
  input  logic            reg_write_m,
  input  logic            reg_write_w,
  output logic [1:0]      fwd
);
  always_comb begin
    fwd = FWD_REG;
    if (reg_write_m && (ra_e == wa3_m))      fwd = FWD_MEM;
    else if (reg_write_w && (ra_e == wa3_w)) fwd = FWD_WB;
  end
endmodule

// File: rtl/hazard_controller.sv
// Hazard / sequencing controller for the 5-stage Filter-GPU datapath.
//   CLK, RST (async, active-low)
//   RA1D/RA2D, RA1E/RA2E, WA3E/M/W, RegWrite*, MemtoRegE : register hazard info
//   PCSrcD/E/M/W, BranchTakenE                           : control-flow info
//   MemOpM, MemReady                                     : data-memory handshake
//   ForwardAE/BE  : operand forward selects
//   StallF/D/E/M  : stage-register holds
//   FlushD/E      : instruction / register buffer clears
//   MemErr        : sticky memory-timeout flag
//   StallCount    : saturating count of cycles with StallF=1
// Build option: FORWARDING_EN. When undefined, forwarding is off and any
// read-after-write against E/M/W stalls Decode instead of load-use only.
module hazard_controller
  import filter_gpu_pkg::*;
#(
  parameter int RA_W        = REG_ADDR_W,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 200,
  parameter int PERF_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [RA_W-1:0]   RA1D,
  input  logic [RA_W-1:0]   RA2D,
  input  logic [RA_W-1:0]   RA1E,
  input  logic [RA_W-1:0]   RA2E,
  input  logic [RA_W-1:0]   WA3E,
  input  logic [RA_W-1:0]   WA3M,
  input  logic [RA_W-1:0]   WA3W,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  input  logic              PCSrcW,
  input  logic              BranchTakenE,
  input  logic              MemOpM,
  input  logic              MemReady,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              MemErr,
  output logic [PERF_W-1:0] StallCount
);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  hz_state_t         state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [1:0] fwd_a, fwd_b;
  logic       hz_stall, pc_pend, freeze, to_abort;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;

  // With forwarding disabled the selectors see no writers, so they sit at 00.
`ifdef FORWARDING_EN
  localparam logic FWD_ON = 1'b1;
  assign hz_stall = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));
`else
  localparam logic FWD_ON = 1'b0;
  logic unused_memtoreg;
  assign unused_memtoreg = MemtoRegE;
  assign hz_stall = (RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E)))
                  | (RegWriteM & ((RA1D == WA3M) | (RA2D == WA3M)))
                  | (RegWriteW & ((RA1D == WA3W) | (RA2D == WA3W)));
`endif

  hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .ra_e(RA1E), .wa3_m(WA3M), .wa3_w(WA3W),
    .reg_write_m(RegWriteM & FWD_ON), .reg_write_w(RegWriteW & FWD_ON),
    .fwd(fwd_a)
  );
  hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .ra_e(RA2E), .wa3_m(WA3M), .wa3_w(WA3W),
    .reg_write_m(RegWriteM & FWD_ON), .reg_write_w(RegWriteW & FWD_ON),
    .fwd(fwd_b)
  );

  assign pc_pend = PCSrcD | PCSrcE | PCSrcM;

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    mem_err_d = mem_err_q;
    freeze    = 1'b0;
    to_abort  = 1'b0;
    case (state_q)
      RUN: begin
        // The stall must already be up on the cycle the miss is seen.
        if (MemOpM && !MemReady) begin
          freeze   = 1'b1;
          state_d  = MEM_WAIT;
          to_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        // Ready is checked first so a late response is never reported as a timeout.
        if (MemReady) begin
          state_d  = RUN;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = RUN;
          to_cnt_d  = '0;
          to_abort  = 1'b1;
          mem_err_d = 1'b1;
        end else begin
          freeze   = 1'b1;
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    // Memory freeze outranks load-use and branch handling; a branch seen while
    // frozen stays held in E and is acted on once the freeze lifts.
    if (freeze) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_d = 1'b0;
      flush_e = 1'b0;
    end else begin
      stall_f = hz_stall | pc_pend;
      stall_d = hz_stall;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = pc_pend | PCSrcW | BranchTakenE;
      // An aborted memory op must not retire.
      flush_e = hz_stall | BranchTakenE | to_abort;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_f && (stall_cnt_q != {PERF_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= RUN;
      to_cnt_q    <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Reset holds both buffers cleared and nothing stalled.
  assign ForwardAE  = RST ? fwd_a : 2'b00;
  assign ForwardBE  = RST ? fwd_b : 2'b00;
  assign StallF     = RST & stall_f;
  assign StallD     = RST & stall_d;
  assign StallE     = RST & stall_e;
  assign StallM     = RST & stall_m;
  assign FlushD     = ~RST | flush_d;
  assign FlushE     = ~RST | flush_e;
  assign MemErr     = mem_err_q;
  assign StallCount = stall_cnt_q;
endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [1:0] F_M = FWD ? 2'b10 : 2'b00;
  localparam logic [1:0] F_W = FWD ? 2'b01 : 2'b00;
  // Outcome of a register dependency that only stalls when forwarding is off.
  localparam logic [3:0] RS = FWD ? 4'b0000 : 4'b1100;
  localparam logic [1:0] RF = FWD ? 2'b00 : 2'b01;

  logic       CLK = 1'b0, RST;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemOpM, MemReady;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr;
  logic [3:0] StallCount;

  hazard_controller #(.RA_W(4), .TO_W(8), .MEM_TIMEOUT(8), .PERF_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemOpM(MemOpM), .MemReady(MemReady),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .MemErr(MemErr), .StallCount(StallCount)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] fae;
    logic [1:0] fbe;
    logic [3:0] stl;  // {F,D,E,M}
    logic [1:0] fl;   // {D,E}
    logic       err;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, mcyc = 0;
  logic       m_err = 1'b0;
  logic [3:0] m_cnt = 4'd0;

  task automatic clr();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'hF; WA3M = 4'hF; WA3W = 4'hF;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
    BranchTakenE = 1'b0; MemOpM = 1'b0; MemReady = 1'b0;
  endtask

  task automatic nc();
    @(posedge CLK);
    #1;
    clr();
  endtask

  // Push the expected response for the current cycle; the stall counter
  // model advances from the expected StallF.
  task automatic ex(input logic [1:0] fae, input logic [1:0] fbe,
                    input logic [3:0] stl, input logic [1:0] fl);
    exp_t e;
    e.fae = fae; e.fbe = fbe; e.stl = stl; e.fl = fl;
    e.err = m_err; e.cnt = m_cnt;
    sb.push_back(e);
    if (stl[3] && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
  endtask

  task automatic rst_cyc();
    nc();
    RST = 1'b0;
    m_err = 1'b0;
    m_cnt = 4'd0;
    ex(2'b00, 2'b00, 4'b0000, 2'b11);
  endtask

  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      mcyc++;
      checks++;
      if ({ForwardAE, ForwardBE} !== {e.fae, e.fbe}) begin
        errors++;
        $display("FAIL fwd cyc %0d got %b_%b exp %b_%b", mcyc, ForwardAE, ForwardBE, e.fae, e.fbe);
      end
      checks++;
      if ({StallF, StallD, StallE, StallM} !== e.stl) begin
        errors++;
        $display("FAIL stall cyc %0d got %b exp %b", mcyc, {StallF, StallD, StallE, StallM}, e.stl);
      end
      checks++;
      if ({FlushD, FlushE} !== e.fl) begin
        errors++;
        $display("FAIL flush cyc %0d got %b exp %b", mcyc, {FlushD, FlushE}, e.fl);
      end
      checks++;
      if (MemErr !== e.err) begin
        errors++;
        $display("FAIL memerr cyc %0d got %b exp %b", mcyc, MemErr, e.err);
      end
      checks++;
      if (StallCount !== e.cnt) begin
        errors++;
        $display("FAIL stallcount cyc %0d got %0d exp %0d", mcyc, StallCount, e.cnt);
      end
    end
  end

  initial begin
    clr();
    RST = 1'b0;
    // Reset holds outputs regardless of inputs.
    nc(); RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3; MemOpM = 1'b1; PCSrcD = 1'b1;
    ex(2'b00, 2'b00, 4'b0000, 2'b11);
    nc(); ex(2'b00, 2'b00, 4'b0000, 2'b11);

    // Forwarding, M over W priority.
    nc(); RST = 1'b1;
    RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3; RegWriteW = 1'b1; WA3W = 4'd3;
    ex(F_M, 2'b00, 4'b0000, 2'b00);
    nc(); RegWriteW = 1'b1; WA3W = 4'd3; RA1E = 4'd3; RA2E = 4'd3;
    ex(F_W, F_W, 4'b0000, 2'b00);
    nc(); RegWriteM = 1'b1; WA3M = 4'd4; RegWriteW = 1'b1; WA3W = 4'd4; RA1E = 4'd4; RA2E = 4'd4;
    ex(F_M, F_M, 4'b0000, 2'b00);
    nc(); RegWriteM = 1'b1; WA3M = 4'd4; RA2E = 4'd4; RegWriteW = 1'b1; WA3W = 4'd5; RA1E = 4'd5;
    ex(F_W, F_M, 4'b0000, 2'b00);
    nc(); WA3M = 4'd3; RA1E = 4'd3;
    ex(2'b00, 2'b00, 4'b0000, 2'b00);

    // Load-use, then the load forwarded from M.
    nc(); MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
    ex(2'b00, 2'b00, 4'b1100, 2'b01);
    nc(); RegWriteM = 1'b1; WA3M = 4'd5; RA2E = 4'd5;
    ex(2'b00, F_M, 4'b0000, 2'b00);
    nc(); MemtoRegE = 1'b1; WA3E = 4'd5; RA1D = 4'd5;
    ex(2'b00, 2'b00, 4'b0000, 2'b00);

    // PC write moving D->E->M->W, then a taken branch.
    nc(); PCSrcD = 1'b1; ex(2'b00, 2'b00, 4'b1000, 2'b10);
    nc(); PCSrcE = 1'b1; ex(2'b00, 2'b00, 4'b1000, 2'b10);
    nc(); PCSrcM = 1'b1; ex(2'b00, 2'b00, 4'b1000, 2'b10);
    nc(); PCSrcW = 1'b1; ex(2'b00, 2'b00, 4'b0000, 2'b10);
    nc(); BranchTakenE = 1'b1; ex(2'b00, 2'b00, 4'b0000, 2'b11);

    // RAW dependencies that stall only without forwarding.
    nc(); RegWriteW = 1'b1; WA3W = 4'd2; RA1D = 4'd2;
    ex(2'b00, 2'b00, RS, RF);
    nc(); RegWriteM = 1'b1; WA3M = 4'd7; RA2D = 4'd7;
    ex(2'b00, 2'b00, RS, RF);

    // Memory wait: four stalled cycles, branch ignored while frozen.
    rst_cyc();
    nc(); RST = 1'b1; MemOpM = 1'b1; ex(2'b00, 2'b00, 4'b1111, 2'b00);
    nc(); MemOpM = 1'b1; ex(2'b00, 2'b00, 4'b1111, 2'b00);
    nc(); MemOpM = 1'b1; BranchTakenE = 1'b1; ex(2'b00, 2'b00, 4'b1111, 2'b00);
    nc(); MemOpM = 1'b1; ex(2'b00, 2'b00, 4'b1111, 2'b00);
    nc(); MemOpM = 1'b1; MemReady = 1'b1; ex(2'b00, 2'b00, 4'b0000, 2'b00);
    nc(); ex(2'b00, 2'b00, 4'b0000, 2'b00);

    // Timeout: 8 stalled cycles, then abort with FlushE and sticky MemErr.
    for (int i = 0; i < 8; i++) begin
      nc(); MemOpM = 1'b1; ex(2'b00, 2'b00, 4'b1111, 2'b00);
    end
    nc(); MemOpM = 1'b1; ex(2'b00, 2'b00, 4'b0000, 2'b01);
    m_err = 1'b1;
    nc(); ex(2'b00, 2'b00, 4'b0000, 2'b00);
    nc(); ex(2'b00, 2'b00, 4'b0000, 2'b00);
    rst_cyc();

    // Ready on the timeout cycle wins: no error, no flush.
    nc(); RST = 1'b1; MemOpM = 1'b1; ex(2'b00, 2'b00, 4'b1111, 2'b00);
    for (int i = 0; i < 7; i++) begin
      nc(); MemOpM = 1'b1; ex(2'b00, 2'b00, 4'b1111, 2'b00);
    end
    nc(); MemOpM = 1'b1; MemReady = 1'b1; ex(2'b00, 2'b00, 4'b0000, 2'b00);
    nc(); ex(2'b00, 2'b00, 4'b0000, 2'b00);

    // Stall counter saturates at all-ones.
    for (int i = 0; i < 16; i++) begin
      nc(); PCSrcD = 1'b1; ex(2'b00, 2'b00, 4'b1000, 2'b10);
    end
    nc(); ex(2'b00, 2'b00, 4'b0000, 2'b00);
    nc(); ex(2'b00, 2'b00, 4'b0000, 2'b00);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard/sequencing controller for the 5-stage vector Filter-GPU datapath (Fetch, Decode, Execute, Memory, Writeback).
- Drives the operand-forward mux selects and the stage-buffer enable/clear signals: fetch enable, instruction buffer, register buffer, ALU buffer.
- Adds a memory-wait FSM that freezes the pipeline for multi-cycle data memory, a timeout detector and a stall performance counter.

Parameters:
- RA_W, 4, register address width (matches instruction field [15:12]).
- TO_W, 8, width of the memory-wait timeout counter.
- MEM_TIMEOUT, 200, cycles in MEM_WAIT before abort; must fit in TO_W bits.
- PERF_W, 16, stall counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-low.
- RA1D, RA2D  in  RA_W  source regs in Decode.
- RA1E, RA2E  in  RA_W  source regs in Execute.
- WA3E, WA3M, WA3W  in  RA_W  destination regs in E/M/W.
- RegWriteE, RegWriteM, RegWriteW  in  1  write-enable per stage.
- MemtoRegE  in  1  load in Execute.
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  PC-write pending per stage.
- BranchTakenE  in  1  branch resolved taken.
- MemOpM  in  1  load/store in Memory.
- MemReady  in  1  data memory done this cycle.
- ForwardAE, ForwardBE  out  2  00 regfile, 01 ResultW, 10 ALUResultM.
- StallF, StallD, StallE, StallM  out  1  hold stage register.
- FlushD, FlushE  out  1  clear instruction/register buffer.
- MemErr  out  1  sticky timeout flag.
- StallCount  out  PERF_W  saturating count of stalled cycles.

Behaviour:
- Reset (RST=0, async): state=RUN, timeout counter=0, MemErr=0, StallCount=0. While RST=0: FlushD=FlushE=1, all Stall*=0, Forward*=00.
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM & RA1E==WA3M.
  - Else 01 if RegWriteW & RA1E==WA3W.
  - Else 00.
  - M has priority over W. ForwardBE is the same using RA2E.
- LdStall = MemtoRegE & RegWriteE & (RA1D==WA3E | RA2D==WA3E).
- PCPend = PCSrcD | PCSrcE | PCSrcM.
- RUN-state outputs:
  - StallF = LdStall | PCPend.
  - StallD = LdStall.
  - StallE = StallM = 0.
  - FlushD = PCPend | PCSrcW | BranchTakenE.
  - FlushE = LdStall | BranchTakenE.
- FSM states RUN and MEM_WAIT.
- RUN -> MEM_WAIT when MemOpM & !MemReady. The transition cycle itself already asserts all four stalls (combinational from MemOpM/MemReady) and forces flushes to 0.
- MEM_WAIT:
  - StallF/D/E/M=1, FlushD=FlushE=0.
  - Timeout counter increments each cycle.
  - MemReady=1 -> RUN; the counter clears and the stalls drop in the same cycle, so the pipeline advances on that edge.
  - Counter reaching MEM_TIMEOUT-1 with MemReady=0 -> RUN, MemErr set (sticky until reset), and FlushE=1 on the exit cycle so the aborted op does not retire.
  - MemReady and timeout in the same cycle: MemReady wins and MemErr is not set.
- Memory-wait freeze outranks load-use and branch handling. BranchTakenE arriving during MEM_WAIT is held by StallE and acted on after exit.
- StallCount increments on every cycle with StallF=1 and saturates at all-ones (no wrap).
- Address match compares raw RA_W bits; register 0 is not special.

Optional Feature:
- Macro FORWARDING_EN.
- Defined: forwarding as above.
- Undefined:
  - ForwardAE=ForwardBE=00 constantly.
  - LdStall is replaced by RawStall: RA1D or RA2D matches a destination in E (RegWriteE), M (RegWriteM) or W (RegWriteW).
  - RawStall drives StallF, StallD and FlushE exactly as LdStall did.

Decomposition:
- Package filter_gpu_pkg:
  - typedef fwd_sel_t (2-bit enum FWD_REG, FWD_WB, FWD_MEM).
  - typedef hz_state_t (RUN, MEM_WAIT).
  - constant REG_ADDR_W=4.
- One sub-module, hazard_fwd_sel: the combinational forward-select logic, instantiated twice (operand A and B).

Test Plan:
- RegWriteM=1, WA3M=3, RA1E=3, RegWriteW=1, WA3W=3 -> ForwardAE=10; then RegWriteM=0 -> ForwardAE=01.
- MemtoRegE=1, RegWriteE=1, WA3E=5, RA2D=5 -> one cycle StallF=StallD=FlushE=1; next cycle (load now in M) -> ForwardBE=10, no stall.
- PCSrcD=1 propagated D->E->M->W -> StallF=1 for 3 cycles, FlushD=1 for 4 cycles; BranchTakenE=1 alone -> FlushD=FlushE=1 for one cycle.
- MemOpM=1, MemReady low 4 cycles then high -> all Stall*=1 for 4 cycles, zero on ready cycle, StallCount=4, MemErr=0.
- MEM_TIMEOUT=8, MemReady never asserted -> exit after 8 stalled cycles, FlushE=1 on exit cycle, MemErr=1 until RST pulsed low mid-run, then MemErr=0 and StallCount=0 asynchronously.
- FORWARDING_EN undefined, RegWriteW=1, WA3W=2, RA1D=2 -> StallF=StallD=1, ForwardAE=00.
